tv80_reg_arb: RTL

- Arbiter and sequencer for the TV80 register-file write/read port A.
- Shares port A between the CPU core and a debug agent. Supports single 16-bit register-pair reads and writes, plus a bulk dump of all pairs.
- Sits between the core's register-file control outputs and the register-file instance.
- Stalls the core through core_wait while the debug agent owns the port.

---
 rtl/tv80_reg_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tv80_reg_arb.sv
// Arbitrates TV80 register-file port A between the core and a debug agent,
// supporting single 16-bit pair accesses and a bulk dump of all pairs.
module tv80_reg_arb #(
  parameter int unsigned NPAIRS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  core_AddrA,
  input  logic [7:0]  core_DIH,
  input  logic [7:0]  core_DIL,
  input  logic        core_WEH,
  input  logic        core_WEL,
  input  logic        core_CEN,
  output logic        core_wait,
  output logic [2:0]  rf_AddrA,
  output logic [7:0]  rf_DIH,
  output logic [7:0]  rf_DIL,
  output logic        rf_WEH,
  output logic        rf_WEL,
  output logic        rf_CEN,
  input  logic [7:0]  rf_DOAH,
  input  logic [7:0]  rf_DOAL,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [2:0]  dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [15:0] dbg_rdata,
  input  logic        dump_start,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [2:0]  dump_addr,
  output logic [15:0] dump_data,
  output logic        dump_done
);

  localparam int unsigned AW = 3;
  localparam logic [AW-1:0] LAST = AW'(NPAIRS - 1);

  typedef enum logic [2:0] {IDLE, STALL, ACCESS, DUMP, RELEASE} state_t;

  state_t        state;
  logic          targetDump;
  logic [AW-1:0] counter;

  // Sequencer: every status output is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      targetDump <= 1'b0;
      counter    <= '0;
      dbg_rdata  <= '0;
      core_wait  <= 1'b0;
      dbg_ack    <= 1'b0;
      dump_done  <= 1'b0;
      dump_valid <= 1'b0;
    end else begin
      dbg_ack   <= 1'b0;
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          // Debug access has priority; a pending dump waits for the next IDLE.
          if (dbg_req) begin
            state      <= STALL;
            targetDump <= 1'b0;
            core_wait  <= 1'b1;
          end else if (dump_start) begin
            state      <= STALL;
            targetDump <= 1'b1;
            core_wait  <= 1'b1;
          end
        end
        STALL: begin
          if (targetDump) begin
            state      <= DUMP;
            dump_valid <= 1'b1;
          end else begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!dbg_we) dbg_rdata <= {rf_DOAH, rf_DOAL};
          state     <= RELEASE;
          core_wait <= 1'b0;
          dbg_ack   <= 1'b1;
        end
        DUMP: begin
          if (dump_ready) begin
            if (counter == LAST) begin
              counter    <= '0;
              dump_valid <= 1'b0;
              core_wait  <= 1'b0;
              dump_done  <= 1'b1;
              state      <= RELEASE;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port-A mux: the core owns the port except during ACCESS and DUMP.
  always_comb begin
    rf_AddrA = core_AddrA;
    rf_DIH   = core_DIH;
    rf_DIL   = core_DIL;
    rf_WEH   = core_WEH;
    rf_WEL   = core_WEL;
    rf_CEN   = core_CEN;
    case (state)
      ACCESS: begin
        rf_AddrA        = dbg_addr;
        {rf_DIH, rf_DIL} = dbg_wdata;
        rf_WEH          = dbg_we;
        rf_WEL          = dbg_we;
        rf_CEN          = 1'b1;
      end
      DUMP: begin
        rf_AddrA = counter;
        rf_DIH   = '0;
        rf_DIL   = '0;
        rf_WEH   = 1'b0;
        rf_WEL   = 1'b0;
        rf_CEN   = 1'b1;
      end
      default: ;
    endcase
  end

  assign dump_addr = counter;
  assign dump_data = {rf_DOAH, rf_DOAL};

endmodule
